// File: rtl/bbs_generator.sv
// Blum Blum Shub generator: x <- x^2 mod MOD via a bit-serial interleaved
// modular multiplier; the LSB of each new state is packed into output words.
//
// state  | meaning
// IDLE   | waiting for enable (and no pending word) to start a step
// SQUARE | one multiplier bit per cycle, MSB first
// COMMIT | x <- acc, shift acc[0] into the output word
// HOLD   | word pending, waiting for out_valid & out_ready
module bbs_generator #(
    parameter int          SIZE     = 16,
    parameter int unsigned MOD      = 40633,
    parameter int unsigned SEED     = 3,
    parameter int          OUT_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                seed_load,
    input  logic [SIZE-1:0]     seed_in,
    output logic                seed_err,
    output logic [OUT_BITS-1:0] out_word,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SIZE-1:0]     state_out
);

    localparam int BW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int CW = $clog2(OUT_BITS + 1);
    localparam logic [SIZE+1:0] MOD_EXT  = (SIZE+2)'(MOD);
    localparam logic [SIZE-1:0] SEED_VAL = SIZE'(SEED);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SQUARE = 2'd1,
        COMMIT = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [SIZE-1:0]     x_q, x_d;
    logic [SIZE+1:0]     acc_q, acc_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [OUT_BITS-1:0] shift_q, shift_d;
    logic [OUT_BITS-1:0] word_q, word_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic                seed_ok;
    logic [SIZE+1:0]     t_sum, t_red1, t_red2;
    logic [OUT_BITS-1:0] shifted;

    // acc < MOD keeps t below 3*MOD, so two conditional subtractions suffice.
    always_comb begin
        t_sum  = (acc_q << 1) + (x_q[bit_q] ? {2'b00, x_q} : '0);
        t_red1 = (t_sum  >= MOD_EXT) ? (t_sum  - MOD_EXT) : t_sum;
        t_red2 = (t_red1 >= MOD_EXT) ? (t_red1 - MOD_EXT) : t_red1;
    end

    assign seed_ok = (seed_in != '0) && ({2'b00, seed_in} < MOD_EXT);
    assign shifted = (shift_q << 1) | OUT_BITS'(acc_q[0]);

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_q;
        valid_d = valid_q;
        err_d   = 1'b0;

        if (seed_load && seed_ok) begin
            x_d     = seed_in;
            acc_d   = '0;
            bit_d   = '0;
            cnt_d   = '0;
            shift_d = '0;
            valid_d = 1'b0;
            state_d = IDLE;
        end else begin
            err_d = seed_load;
            unique case (state_q)
                IDLE: begin
                    if (!valid_q && enable) begin
                        acc_d   = '0;
                        bit_d   = BW'(SIZE - 1);
                        state_d = SQUARE;
                    end
                end
                SQUARE: begin
                    acc_d = t_red2;
                    if (bit_q == '0) begin
                        state_d = COMMIT;
                    end else begin
                        bit_d = bit_q - 1'b1;
                    end
                end
                COMMIT: begin
                    x_d     = acc_q[SIZE-1:0];
                    shift_d = shifted;
                    if (cnt_q == CW'(OUT_BITS - 1)) begin
                        word_d  = shifted;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = HOLD;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = IDLE;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= SEED_VAL;
            acc_q   <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign state_out = x_q;
    assign out_word  = word_q;
    assign out_valid = valid_q;
    assign seed_err  = err_q;

endmodule
